// File: rtl/bitbakery_serial_tx_seq.sv
// Message sequencer for a serial tx core: walks the word index, fires one start
// pulse per word, waits for the core's done pulse, and inserts idle gaps between words.
module bitbakery_serial_tx_seq #(
    parameter int NUM_WORDS  = 4,
    parameter int GAP_CYCLES = 0,
    parameter int IDX_W      = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             iniciar_seq,
    input  logic             continuo,
    input  logic             parar,
    input  logic             fim_tx,
    output logic             iniciar,
    output logic [IDX_W-1:0] indice,
    output logic             ocupado,
    output logic             fim_seq
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        START_TX = 3'd1,
        WAIT_TX  = 3'd2,
        GAP      = 3'd3,
        NEXT_TX  = 3'd4
    } state_t;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_WORDS - 1);
    localparam logic [7:0]       GAP_LAST = 8'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);
    localparam bit               HAS_GAP  = (GAP_CYCLES > 0);

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] idx_q;
    logic [IDX_W-1:0] idx_next;
    logic [7:0]       gap_cnt;
    logic [7:0]       gap_next;
    logic             last_word;

    assign last_word = (idx_q == LAST_IDX);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            idx_q   <= '0;
            gap_cnt <= '0;
        end else begin
            state   <= state_next;
            idx_q   <= idx_next;
            gap_cnt <= gap_next;
        end
    end

    // NOTE: every variable gets a default before the case so no path can leave
    // it unassigned and infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (iniciar_seq && !parar) begin
                    state_next = START_TX;
                end
            end
            START_TX: state_next = WAIT_TX;
            WAIT_TX: begin
                if (fim_tx) begin
                    state_next = HAS_GAP ? GAP : NEXT_TX;
                end
            end
            GAP: begin
                if (gap_cnt == GAP_LAST) begin
                    state_next = NEXT_TX;
                end
            end
            NEXT_TX: begin
                if (last_word) begin
                    state_next = continuo ? START_TX : IDLE;
                end else begin
                    state_next = START_TX;
                end
            end
            default: state_next = IDLE;
        endcase

        // Abort overrides everything, including a pending restart from NEXT_TX.
        if (parar && (state != IDLE)) begin
            state_next = IDLE;
        end
    end

    // Index advances only on leaving NEXT_TX, keeping it stable for the whole word.
    always_comb begin
        idx_next = idx_q;
        gap_next = (state == GAP) ? (gap_cnt + 8'd1) : 8'd0;
        if (state == NEXT_TX) begin
            idx_next = last_word ? '0 : (idx_q + 1'b1);
        end
        if (state_next == IDLE) begin
            idx_next = '0;
        end
    end

    always_comb begin
        iniciar = (state == START_TX);
        ocupado = (state != IDLE);
        fim_seq = (state == NEXT_TX) && last_word;
        indice  = idx_q;
    end

endmodule

// File: tb/tb_bitbakery_serial_tx_seq.sv
// Scoreboard bench: tests queue the expected start/fim_seq events, a monitor
// pops and compares them as the sequencer emits them.
module tb_bitbakery_serial_tx_seq;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       iniciar_seq = 1'b0;
    logic       continuo = 1'b0;
    logic       parar = 1'b0;
    logic       fim_tx;
    logic       iniciar;
    logic [1:0] indice;
    logic       ocupado;
    logic       fim_seq;

    logic       iniciar_seq_b = 1'b0;
    logic       continuo_b = 1'b0;
    logic       fim_tx_b = 1'b0;
    logic       iniciar_b;
    logic [0:0] indice_b;
    logic       ocupado_b;
    logic       fim_seq_b;

    logic       resp_fim = 1'b0;
    logic       man_fim = 1'b0;
    logic       resp_en = 1'b1;

    int n_tests = 0;
    int n_fail = 0;

    typedef struct packed {
        logic       is_fin;
        logic [1:0] idx;
    } exp_t;
    exp_t exp_q[$];

    assign fim_tx = resp_fim | man_fim;

    always #5 clock = ~clock;

    bitbakery_serial_tx_seq #(.NUM_WORDS(3), .GAP_CYCLES(2), .IDX_W(2)) dut (
        .clock(clock), .reset_n(reset_n), .iniciar_seq(iniciar_seq), .continuo(continuo),
        .parar(parar), .fim_tx(fim_tx), .iniciar(iniciar), .indice(indice),
        .ocupado(ocupado), .fim_seq(fim_seq)
    );

    bitbakery_serial_tx_seq #(.NUM_WORDS(1), .GAP_CYCLES(0), .IDX_W(1)) dut_b (
        .clock(clock), .reset_n(reset_n), .iniciar_seq(iniciar_seq_b), .continuo(continuo_b),
        .parar(1'b0), .fim_tx(fim_tx_b), .iniciar(iniciar_b), .indice(indice_b),
        .ocupado(ocupado_b), .fim_seq(fim_seq_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic push_msg();
        for (int i = 0; i < 3; i++) exp_q.push_back('{1'b0, 2'(i)});
        exp_q.push_back('{1'b1, 2'd0});
    endtask

    // Tx core model: done pulse during the third cycle after each start.
    always begin
        @(negedge clock);
        if (reset_n && resp_en && iniciar) begin
            repeat (3) @(negedge clock);
            resp_fim = 1'b1;
            @(negedge clock);
            resp_fim = 1'b0;
        end
    end

    always @(negedge clock) begin
        if (reset_n && (iniciar || fim_seq)) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_event", {30'd0, iniciar, fim_seq}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("sb_event_kind", fim_seq, e.is_fin);
                if (iniciar) check("sb_indice", indice, e.idx);
            end
        end
    end

    task automatic start_msg();
        @(negedge clock);
        iniciar_seq = 1'b1;
        @(negedge clock);
        iniciar_seq = 1'b0;
        check("start_latency", iniciar, 1);
    endtask

    task automatic wait_idle(input int budget);
        bit done;
        done = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (!ocupado) begin
                done = 1'b1;
                break;
            end
        end
        check("idle_reached", done, 1);
    endtask

    task automatic wait_iniciar(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (iniciar) begin
                seen = 1'b1;
                break;
            end
        end
        check("iniciar_seen", seen, 1);
    endtask

    // Hand-driven word 0: optional stray fim_tx in START_TX and in GAP.
    task automatic gap_probe(input bit stray);
        resp_en = 1'b0;
        push_msg();
        start_msg();
        man_fim = stray;
        @(negedge clock);
        man_fim = 1'b0;
        check("gp_wait_busy", ocupado, 1);
        check("gp_wait_no_start", iniciar, 0);
        @(negedge clock);
        man_fim = 1'b1;
        @(negedge clock);
        man_fim = stray;
        check("gp_gap1_no_start", iniciar, 0);
        @(negedge clock);
        man_fim = 1'b0;
        check("gp_gap2_no_start", iniciar, 0);
        @(negedge clock);
        check("gp_next_no_start", iniciar, 0);
        check("gp_next_no_fim", fim_seq, 0);
        resp_en = 1'b1;
        @(negedge clock);
        check("gp_word1_start", iniciar, 1);
        check("gp_word1_indice", indice, 1);
        wait_idle(100);
        check("gp_drained", exp_q.size(), 0);
    endtask

    initial begin
        int nf;
        int idle_seen;
        #1;
        check("rst_ocupado", ocupado, 0);
        check("rst_iniciar", iniciar, 0);
        check("rst_fim_seq", fim_seq, 0);
        check("rst_indice", indice, 0);
        @(negedge clock);
        reset_n = 1'b1;

        // Stray fim_tx in IDLE, then simultaneous parar + iniciar_seq.
        @(negedge clock);
        man_fim = 1'b1;
        repeat (2) @(negedge clock);
        man_fim = 1'b0;
        check("idle_stray_ocupado", ocupado, 0);
        parar = 1'b1;
        iniciar_seq = 1'b1;
        @(negedge clock);
        parar = 1'b0;
        iniciar_seq = 1'b0;
        check("parar_wins_idle", ocupado, 0);
        @(negedge clock);
        check("parar_wins_no_start", iniciar, 0);

        // One-shot message.
        push_msg();
        start_msg();
        wait_idle(100);
        check("oneshot_drained", exp_q.size(), 0);

        gap_probe(1'b0);
        gap_probe(1'b1);

        // Continuous mode over two messages, no idle cycle in between.
        continuo = 1'b1;
        push_msg();
        push_msg();
        start_msg();
        nf = 0;
        idle_seen = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clock);
            if (!ocupado) idle_seen++;
            if (fim_seq) begin
                nf++;
                if (nf == 2) begin
                    continuo = 1'b0;
                    break;
                end
            end
        end
        check("cont_no_idle", idle_seen, 0);
        check("cont_fim_count", nf, 2);
        wait_idle(10);
        check("cont_drained", exp_q.size(), 0);

        // Abort in WAIT_TX of word 1, then restart from index 0.
        exp_q.push_back('{1'b0, 2'd0});
        exp_q.push_back('{1'b0, 2'd1});
        start_msg();
        wait_iniciar(20);
        @(negedge clock);
        parar = 1'b1;
        @(negedge clock);
        parar = 1'b0;
        check("abort_idle", ocupado, 0);
        check("abort_indice", indice, 0);
        check("abort_no_fim", fim_seq, 0);
        repeat (6) @(negedge clock);
        check("abort_drained", exp_q.size(), 0);
        push_msg();
        start_msg();
        wait_idle(100);
        check("restart_drained", exp_q.size(), 0);

        // Async reset in the middle of the word-1 gap.
        exp_q.push_back('{1'b0, 2'd0});
        exp_q.push_back('{1'b0, 2'd1});
        start_msg();
        wait_iniciar(20);
        repeat (4) @(negedge clock);
        check("pre_rst_busy", ocupado, 1);
        check("pre_rst_indice", indice, 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_ocupado", ocupado, 0);
        check("async_rst_indice", indice, 0);
        check("async_rst_iniciar", iniciar, 0);
        check("async_rst_fim_seq", fim_seq, 0);
        @(negedge clock);
        reset_n = 1'b1;
        check("rst_drained", exp_q.size(), 0);
        push_msg();
        start_msg();
        wait_idle(100);
        check("post_rst_drained", exp_q.size(), 0);

        // Single-word, no-gap instance: every word ends the message.
        continuo_b = 1'b1;
        @(negedge clock);
        iniciar_seq_b = 1'b1;
        @(negedge clock);
        iniciar_seq_b = 1'b0;
        check("b_latency", iniciar_b, 1);
        for (int w = 0; w < 3; w++) begin
            if (w > 0) begin
                @(negedge clock);
                check("b_iniciar", iniciar_b, 1);
            end
            @(negedge clock);
            fim_tx_b = 1'b1;
            if (w == 2) continuo_b = 1'b0;
            @(negedge clock);
            fim_tx_b = 1'b0;
            check("b_fim_seq", fim_seq_b, 1);
            check("b_indice", indice_b, 0);
        end
        @(negedge clock);
        check("b_idle", ocupado_b, 0);

        check("final_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
